ccr_unit: RTL and testbench

//  Condition-code register directly downstream of the 8-bit ALU. Commits the ALU's Z/N/C/V only for flags the op defines.

---
 rtl/cpu_pkg.sv | 41 ++++
 rtl/ccr_unit_if.sv | 45 ++++
 rtl/ccr_shadow_stack.sv | 50 +++++
 rtl/ccr_unit.sv | 87 ++++++++
 tb/tb_ccr_unit.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op codes, CCR flag bit positions,
// branch condition codes and the CCR update masks.
package cpu_pkg;

    localparam logic [3:0] ALU_NOP  = 4'b0000;
    localparam logic [3:0] ALU_PASS = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_SUB  = 4'b0011;
    localparam logic [3:0] ALU_AND  = 4'b0100;
    localparam logic [3:0] ALU_OR   = 4'b0101;
    localparam logic [3:0] ALU_RLC  = 4'b0110;
    localparam logic [3:0] ALU_RRC  = 4'b0111;
    localparam logic [3:0] ALU_SETC = 4'b1000;
    localparam logic [3:0] ALU_CLRC = 4'b1001;
    localparam logic [3:0] ALU_NOT  = 4'b1010;
    localparam logic [3:0] ALU_NEG  = 4'b1011;
    localparam logic [3:0] ALU_INC  = 4'b1100;
    localparam logic [3:0] ALU_DEC  = 4'b1101;

    localparam int CCR_Z = 0;
    localparam int CCR_N = 1;
    localparam int CCR_C = 2;
    localparam int CCR_V = 3;

    localparam logic [1:0] BR_Z = 2'b00;
    localparam logic [1:0] BR_N = 2'b01;
    localparam logic [1:0] BR_C = 2'b10;
    localparam logic [1:0] BR_V = 2'b11;

    // Update masks, bit order {V,C,N,Z}
    localparam logic [3:0] MASK_ALL  = 4'b1111;
    localparam logic [3:0] MASK_ZN   = 4'b0011;
    localparam logic [3:0] MASK_C    = 4'b0100;
    localparam logic [3:0] MASK_NONE = 4'b0000;

    // Width of a counter that must hold 0..depth inclusive
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/ccr_unit_if.sv
// Bundle between the ALU/control unit (master) and the CCR (slave).
// Carries ALU flags, interrupt save/restore, branch query and CCR state.
interface ccr_unit_if #(
    parameter int SHADOW_DEPTH = 2
);
    import cpu_pkg::*;

    localparam int CW = cnt_w(SHADOW_DEPTH);

    logic          stall;
    logic          alu_valid;
    logic [3:0]    alu_sel;
    logic          z_in;
    logic          n_in;
    logic          c_in;
    logic          v_in;
    logic          int_save;
    logic          int_restore;
    logic          br_req;
    logic [1:0]    br_cond;
    logic          br_taken;
    logic [3:0]    ccr;
    logic          cin_out;
    logic [CW-1:0] shadow_cnt;
    logic          stk_err;

    modport master (
        output stall, alu_valid, alu_sel,
        output z_in, n_in, c_in, v_in,
        output int_save, int_restore,
        output br_req, br_cond,
        input  br_taken, ccr, cin_out,
        input  shadow_cnt, stk_err
    );

    modport slave (
        input  stall, alu_valid, alu_sel,
        input  z_in, n_in, c_in, v_in,
        input  int_save, int_restore,
        input  br_req, br_cond,
        output br_taken, ccr, cin_out,
        output shadow_cnt, stk_err
    );

endinterface

// File: rtl/ccr_shadow_stack.sv
// LIFO of saved CCR values for interrupt nesting.
// Ports: push_i/pop_i/din_i in; dout_o (top), count_o, full_o, empty_o out.
module ccr_shadow_stack
    import cpu_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = cnt_w(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [3:0]    din_i,
    output logic [3:0]    dout_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [3:0]    mem_q [DEPTH];
    logic [CW-1:0] cnt_q;

    assign count_o = cnt_q;
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);

    always_comb begin
        dout_o = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (CW'(i + 1) == cnt_q) dout_o = mem_q[i];
        end
    end

    // Push together with pop: the pop wins and the top entry is
    // rewritten with the value it already holds, so nothing moves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (pop_i) begin
            if (!empty_o && !push_i) cnt_q <= cnt_q - 1'b1;
        end else if (push_i && !full_o) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (CW'(i) == cnt_q) mem_q[i] <= din_i;
            end
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/ccr_unit.sv
// Condition-code register {V,C,N,Z} with masked ALU commit, shadow stack
// and branch evaluation. Ports: clk, rst_n, bus (ccr_unit_if.slave).
// Optional CCR_BR_CLR_EN: a taken branch clears the tested flag.
module ccr_unit
    import cpu_pkg::*;
#(
    parameter int SHADOW_DEPTH = 2,
    localparam int CW = cnt_w(SHADOW_DEPTH)
) (
    input  logic       clk,
    input  logic       rst_n,
    ccr_unit_if.slave  bus
);

    logic [3:0]    ccr_q, ccr_d;
    logic          err_q;
    logic [3:0]    mask;
    logic [3:0]    flags;
    logic [3:0]    ccr_next;
    logic          push, pop, err_set;
    logic [3:0]    stk_dout;
    logic [CW-1:0] stk_cnt;
    logic          stk_full, stk_empty;

    assign flags = {bus.v_in, bus.c_in, bus.n_in, bus.z_in};

    always_comb begin
        mask = MASK_NONE;
        if (bus.alu_valid) begin
            unique case (bus.alu_sel)
                ALU_ADD, ALU_SUB, ALU_INC, ALU_DEC:   mask = MASK_ALL;
                ALU_AND, ALU_OR, ALU_NOT, ALU_NEG:    mask = MASK_ZN;
                ALU_RLC, ALU_RRC, ALU_SETC, ALU_CLRC: mask = MASK_C;
                default:                              mask = MASK_NONE;
            endcase
        end
    end

    assign bus.br_taken = bus.br_req & ccr_q[bus.br_cond];

    // Per-bit select so an X on an unmasked flag input never leaks in
    always_comb begin
        ccr_next = ccr_q;
        for (int i = 0; i < 4; i++) begin
            if (mask[i]) ccr_next[i] = flags[i];
        end
`ifdef CCR_BR_CLR_EN
        if (bus.br_taken && !mask[bus.br_cond])
            ccr_next[bus.br_cond] = 1'b0;
`endif
    end

    assign push    = bus.int_save & ~bus.stall;
    assign pop     = bus.int_restore & ~bus.stall;
    assign err_set = (pop & stk_empty) | (push & ~pop & stk_full);
    assign ccr_d   = (pop && !stk_empty) ? stk_dout : ccr_next;

    ccr_shadow_stack #(
        .DEPTH (SHADOW_DEPTH)
    ) u_stk (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (ccr_next),
        .dout_o  (stk_dout),
        .count_o (stk_cnt),
        .full_o  (stk_full),
        .empty_o (stk_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ccr_q <= '0;
            err_q <= 1'b0;
        end else if (!bus.stall) begin
            ccr_q <= ccr_d;
            if (err_set) err_q <= 1'b1;
        end
    end

    assign bus.ccr        = ccr_q;
    assign bus.cin_out    = ccr_q[CCR_C];
    assign bus.shadow_cnt = stk_cnt;
    assign bus.stk_err    = err_q;

endmodule

// File: tb/tb_ccr_unit.sv
// Randomised and directed bench for ccr_unit against a queue-based
// reference model of the condition-code register and shadow stack.
module tb_ccr_unit;
    import cpu_pkg::*;

    localparam int DEPTH = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ccr_unit_if #(.SHADOW_DEPTH(DEPTH)) bus();

    ccr_unit #(.SHADOW_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    logic [3:0] m_ccr;
    logic       m_err;
    logic [3:0] m_stk[$];

    task automatic chk(input string tag, input logic [7:0] got,
                       input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [3:0] mask_of(input logic [3:0] sel);
        case (sel)
            4'd2, 4'd3, 4'd12, 4'd13: return 4'b1111;
            4'd4, 4'd5, 4'd10, 4'd11: return 4'b0011;
            4'd6, 4'd7, 4'd8, 4'd9:   return 4'b0100;
            default:                  return 4'b0000;
        endcase
    endfunction

    task automatic idle();
        bus.stall = 1'b0;
        bus.alu_valid = 1'b0;
        bus.alu_sel = ALU_NOP;
        {bus.v_in, bus.c_in, bus.n_in, bus.z_in} = 4'b0000;
        bus.int_save = 1'b0;
        bus.int_restore = 1'b0;
        bus.br_req = 1'b0;
        bus.br_cond = 2'b00;
    endtask

    task automatic alu(input logic [3:0] sel, input logic [3:0] f);
        bus.alu_valid = 1'b1;
        bus.alu_sel = sel;
        {bus.v_in, bus.c_in, bus.n_in, bus.z_in} = f;
    endtask

    // Reference: what the CCR should hold after this cycle's inputs
    task automatic model_step();
        logic [3:0] m, f, nxt;
        if (bus.stall) return;
        m = bus.alu_valid ? mask_of(bus.alu_sel) : 4'b0000;
        f = {bus.v_in, bus.c_in, bus.n_in, bus.z_in};
        nxt = (f & m) | (m_ccr & ~m);
`ifdef CCR_BR_CLR_EN
        if (bus.br_req && m_ccr[bus.br_cond] && !m[bus.br_cond])
            nxt[bus.br_cond] = 1'b0;
`endif
        if (bus.int_restore) begin
            if (m_stk.size() > 0) begin
                m_ccr = m_stk[$];
                if (!bus.int_save) void'(m_stk.pop_back());
            end else begin
                m_err = 1'b1;
                m_ccr = nxt;
            end
        end else begin
            m_ccr = nxt;
            if (bus.int_save) begin
                if (m_stk.size() == DEPTH) m_err = 1'b1;
                else m_stk.push_back(nxt);
            end
        end
    endtask

    task automatic check_all();
        chk("ccr", 8'(bus.ccr), 8'(m_ccr));
        chk("cin_out", 8'(bus.cin_out), 8'(m_ccr[2]));
        chk("shadow_cnt", 8'(bus.shadow_cnt), 8'(m_stk.size()));
        chk("stk_err", 8'(bus.stk_err), 8'(m_err));
        chk("br_taken", 8'(bus.br_taken),
            8'(bus.br_req & m_ccr[bus.br_cond]));
    endtask

    // Entered 1 time unit after a rising edge, leaves the same way
    task automatic tick();
        @(negedge clk);
        check_all();
        model_step();
        @(posedge clk);
        #1;
    endtask

    // Asynchronous reset in the middle of a cycle, no clock edge used
    task automatic do_reset();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_ccr", 8'(bus.ccr), 8'h00);
        chk("rst_cnt", 8'(bus.shadow_cnt), 8'h00);
        chk("rst_err", 8'(bus.stk_err), 8'h00);
        m_ccr = 4'b0000;
        m_err = 1'b0;
        m_stk.delete();
        #1 rst_n = 1'b1;
    endtask

    initial begin
        idle();
        m_ccr = 4'b0000;
        m_err = 1'b0;
        @(posedge clk);
        #1;
        do_reset();
        idle(); tick();

        // ADD then AND: C from ADD kept, Z/N replaced by AND
        alu(ALU_ADD, 4'b0101); tick();
        alu(ALU_AND, 4'b0010); tick();
        idle();
        chk("add_and", 8'(bus.ccr), 8'h06);
        tick();

        // RLC with unknown Z/N/V inputs, then PASS
        do_reset();
        alu(ALU_RLC, 4'b0100);
        bus.z_in = 1'bx; bus.n_in = 1'bx; bus.v_in = 1'bx;
        tick();
        chk("rlc_mask", 8'(bus.ccr), 8'h04);
        alu(ALU_PASS, 4'b1011); tick();
        chk("pass", 8'(bus.ccr), 8'h04);
        idle(); tick();

        // Nesting with overflow and underflow
        do_reset();
        alu(ALU_ADD, 4'b0001); tick();
        idle(); bus.int_save = 1'b1; tick();
        idle(); alu(ALU_ADD, 4'b0010); tick();
        idle(); bus.int_save = 1'b1; tick();
        tick();
        chk("ovf_err", 8'(bus.stk_err), 8'h01);
        chk("ovf_cnt", 8'(bus.shadow_cnt), 8'h02);
        idle(); bus.int_restore = 1'b1; tick();
        chk("pop1", 8'(bus.ccr), 8'h02);
        tick();
        chk("pop2", 8'(bus.ccr), 8'h01);
        tick();
        chk("udf_ccr", 8'(bus.ccr), 8'h01);
        chk("udf_err", 8'(bus.stk_err), 8'h01);
        idle(); tick();

        // Same-cycle ALU with save, and ALU with restore
        do_reset();
        alu(ALU_SUB, 4'b1010); bus.int_save = 1'b1; tick();
        idle(); alu(ALU_ADD, 4'b0000); tick();
        idle(); bus.int_restore = 1'b1; tick();
        chk("sub_save", 8'(bus.ccr), 8'h0a);
        idle(); bus.int_save = 1'b1; tick();
        idle(); alu(ALU_ADD, 4'b0101); bus.int_restore = 1'b1; tick();
        chk("alu_rest", 8'(bus.ccr), 8'h0a);
        idle(); tick();

        // Branch on C, plain, then with CLRC and with SETC
        for (int k = 0; k < 3; k++) begin
            do_reset();
            alu(ALU_SETC, 4'b0100); tick();
            idle(); bus.br_req = 1'b1; bus.br_cond = BR_C;
            if (k == 1) alu(ALU_CLRC, 4'b0000);
            if (k == 2) alu(ALU_SETC, 4'b0100);
            #1 chk("br_taken_c", 8'(bus.br_taken), 8'h01);
            tick();
`ifdef CCR_BR_CLR_EN
            chk("br_clr", 8'(bus.ccr), (k == 2) ? 8'h04 : 8'h00);
`else
            chk("br_clr", 8'(bus.ccr), (k == 1) ? 8'h00 : 8'h04);
`endif
            idle(); tick();
        end

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            if (i % 600 == 599) do_reset();
            bus.stall = ($urandom_range(7) == 0);
            bus.alu_valid = $urandom_range(1);
            bus.alu_sel = 4'($urandom_range(15));
            {bus.v_in, bus.c_in, bus.n_in, bus.z_in} = 4'($urandom_range(15));
            bus.int_save = ($urandom_range(5) == 0);
            bus.int_restore = ($urandom_range(5) == 0);
            bus.br_req = $urandom_range(1);
            bus.br_cond = 2'($urandom_range(3));
            tick();
        end
        idle();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
